// File: rtl/pbit_update.sv
// -----------------------------------------------------------------------------
// pbit_update -- probabilistic bit (p-bit) state update.
//
// Two-stage pipeline:
//   stage 1 : registers the Q3.2 MAC sum (r_raw) and its valid flag (r_v1).
//             The 9-bit signed activation is a pure function of r_raw, so it
//             changes only when r_raw does and is held in the same stage.
//   stage 2 : when r_v1 is set, compares the activation against an 8-bit
//             signed sample from a 16-bit Fibonacci LFSR, registers the
//             result as p_out, pulses p_valid and advances the LFSR.
//
// Activation transfer (default SLOPE_SHIFT = 3):
//   r_raw >=  16  ->  +128   (always fires, since rnd <= 127)
//   r_raw <= -16  ->  -128   (never fires, since rnd >= -128)
//   otherwise     ->  r_raw << SLOPE_SHIFT, sign-extended to 9 bits
// SLOPE_SHIFT must keep 15 << SLOPE_SHIFT inside the 9-bit signed range.
//
// The LFSR is reloaded by seed_load (priority over advancing); a zero seed
// is replaced by SEED so the register can never lock up at all zeros. SEED
// itself must be non-zero.
//
// Optional feature, enabled by defining PBIT_UPDATE_CLAMP_EN:
//   adds inputs clamp / clamp_val. With clamp = 1 at a stage-2 fire, p_out
//   takes clamp_val instead of the comparison result; p_valid and the LFSR
//   behave exactly as in an unclamped fire, so the random stream does not
//   depend on clamping.
// -----------------------------------------------------------------------------
module pbit_update #(
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          SLOPE_SHIFT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  mac_in,
  input  logic        in_valid,
  input  logic        seed_load,
  input  logic [15:0] seed,
`ifdef PBIT_UPDATE_CLAMP_EN
  input  logic        clamp,
  input  logic        clamp_val,
`endif
  output logic        p_out,
  output logic        p_valid
);

  // ---------------------------------------------------------------------------
  // Stage-1 registers
  // ---------------------------------------------------------------------------
  logic signed [5:0]  r_raw;     // r6: registered MAC sum, Q3.2
  logic               r_v1;      // v1: registered in_valid

  // ---------------------------------------------------------------------------
  // LFSR and stage-2 registers
  // ---------------------------------------------------------------------------
  logic [15:0]        r_lfsr;
  logic               r_p_out;
  logic               r_p_valid;

  // ---------------------------------------------------------------------------
  // Combinational nets
  // ---------------------------------------------------------------------------
  logic signed [8:0]  w_act;        // activation a
  logic signed [8:0]  w_rnd;        // random sample rnd
  logic               w_feedback;   // LFSR feedback bit
  logic [15:0]        w_lfsr_adv;   // LFSR after one shift
  logic [15:0]        w_seed_eff;   // seed with the all-zero case replaced
  logic [15:0]        w_lfsr_next;  // next LFSR state
  logic               w_cmp;        // a > rnd
  logic               w_p_next;     // value p_out takes on a fire

  // Stage 1: free-running capture of the MAC sum and its valid flag.
  // NOTE: clocked state is written with non-blocking (<=) assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raw <= '0;
      r_v1  <= 1'b0;
    end else begin
      r_raw <= mac_in;
      r_v1  <= in_valid;
    end
  end

  // Piecewise-linear activation: saturate outside +/-4.0, linear inside.
  // NOTE: every output of a combinational block gets a default before any
  // branch, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_act = {{3{r_raw[5]}}, r_raw} <<< SLOPE_SHIFT;
    if (r_raw >= 6'sd16) begin
      w_act = 9'sd128;
    end else if (r_raw <= -6'sd16) begin
      w_act = -9'sd128;
    end
  end

  // Random sample: low byte of the LFSR as a signed value, sign-extended.
  always_comb begin
    w_rnd = {r_lfsr[7], r_lfsr[7:0]};
  end

  // LFSR next state: seed load has priority over advancing; hold otherwise.
  always_comb begin
    w_feedback  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    w_lfsr_adv  = {r_lfsr[14:0], w_feedback};
    w_seed_eff  = (seed == 16'h0000) ? SEED : seed;
    w_lfsr_next = r_lfsr;
    if (seed_load) begin
      w_lfsr_next = w_seed_eff;
    end else if (r_v1) begin
      w_lfsr_next = w_lfsr_adv;
    end
  end

  // Stage-2 decision: signed compare, optionally overridden by the clamp.
  always_comb begin
    w_cmp = (w_act > w_rnd);
`ifdef PBIT_UPDATE_CLAMP_EN
    w_p_next = clamp ? clamp_val : w_cmp;
`else
    w_p_next = w_cmp;
`endif
  end

  // LFSR register; reset value is SEED so the state is never all zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= w_lfsr_next;
    end
  end

  // Stage 2: update p_out and pulse p_valid on a fire; hold p_out otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_out   <= 1'b0;
      r_p_valid <= 1'b0;
    end else begin
      r_p_valid <= r_v1;
      if (r_v1) begin
        r_p_out <= w_p_next;
      end
    end
  end

  assign p_out   = r_p_out;
  assign p_valid = r_p_valid;

endmodule

// File: tb/tb_pbit_update.sv
// -----------------------------------------------------------------------------
// tb_pbit_update -- self-checking bench for pbit_update.
// A transaction-level reference model (integer arithmetic on the LFSR value,
// activation and random sample) predicts p_out, p_valid and the LFSR state
// after every clock edge. Define PBIT_UPDATE_CLAMP_EN to exercise the clamp.
// -----------------------------------------------------------------------------
module tb_pbit_update;

  localparam int SEED_V = 'hACE1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  mac_in;
  logic        in_valid;
  logic        seed_load;
  logic [15:0] seed;
  logic        p_out;
  logic        p_valid;
`ifdef PBIT_UPDATE_CLAMP_EN
  logic        clamp;
  logic        clamp_val;
`endif

  pbit_update dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mac_in    (mac_in),
    .in_valid  (in_valid),
    .seed_load (seed_load),
    .seed      (seed),
`ifdef PBIT_UPDATE_CLAMP_EN
    .clamp     (clamp),
    .clamp_val (clamp_val),
`endif
    .p_out     (p_out),
    .p_valid   (p_valid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (pre-edge view of the design)
  int m_lfsr;
  int m_a;
  bit m_v1;
  bit m_p;
  bit m_pv;

  // Observed statistics
  int ones;
  int pulses;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic int act_of(input int x);
    if (x >= 16)  return 128;
    if (x <= -16) return -128;
    return x * 8;
  endfunction

  function automatic int rnd_of(input int l);
    int b;
    b = l % 256;
    return (b >= 128) ? b - 256 : b;
  endfunction

  function automatic int lfsr_adv(input int l);
    int fb;
    fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
    return ((l * 2) % 65536) + fb;
  endfunction

  task automatic model_reset();
    m_lfsr = SEED_V;
    m_a    = 0;
    m_v1   = 1'b0;
    m_p    = 1'b0;
    m_pv   = 1'b0;
  endtask

  // One clock: drive at the falling edge, advance the model, check after the
  // rising edge.
  task automatic step(input int mac, input bit iv, input bit sl, input int sd);
    bit fire_val;
    @(negedge clk);
    mac_in    = 6'(mac);
    in_valid  = iv;
    seed_load = sl;
    seed      = 16'(sd);
    if (m_v1) begin
      fire_val = (m_a > rnd_of(m_lfsr));
`ifdef PBIT_UPDATE_CLAMP_EN
      if (clamp) fire_val = clamp_val;
`endif
      m_p  = fire_val;
      m_pv = 1'b1;
    end else begin
      m_pv = 1'b0;
    end
    if (sl)        m_lfsr = (sd == 0) ? SEED_V : sd;
    else if (m_v1) m_lfsr = lfsr_adv(m_lfsr);
    m_v1 = iv;
    m_a  = act_of(mac);
    @(posedge clk);
    #1;
    check("p_valid", p_valid, m_pv);
    check("p_out",   p_out,   m_p);
    check("lfsr",    dut.r_lfsr, m_lfsr);
    if (p_valid) begin
      pulses++;
      ones += p_out;
    end
  endtask

  task automatic upd(input int mac);
    step(mac, 1'b1, 1'b0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1'b0, 1'b0, 0);
  endtask

  // Reset held low across exactly one rising edge, with async checks.
  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    seed_load = 1'b0;
    mac_in    = '0;
    seed      = '0;
    model_reset();
    #1;
    check("rst_p_out",   p_out,      0);
    check("rst_p_valid", p_valid,    0);
    check("rst_lfsr",    dut.r_lfsr, SEED_V);
    @(negedge clk);
    rst_n = 1'b1;
    ones   = 0;
    pulses = 0;
  endtask

  // Expected LFSR after n advances from SEED.
  function automatic int lfsr_after(input int n);
    int l;
    l = SEED_V;
    for (int i = 0; i < n; i++) l = lfsr_adv(l);
    return l;
  endfunction

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    seed_load = 1'b0;
    mac_in    = '0;
    seed      = '0;
`ifdef PBIT_UPDATE_CLAMP_EN
    clamp     = 1'b0;
    clamp_val = 1'b0;
`endif
    model_reset();

    // Reset then idle: everything stays at reset values.
    do_reset();
    idle(10);
    check("idle_lfsr", dut.r_lfsr, 'hACE1);

    // Positive saturation: every pulse is 1, pulses start on the 2nd edge.
    for (int i = 0; i < 200; i++) upd(31);
    idle(2);
    check("sat_pos_pulses", pulses, 200);
    check("sat_pos_ones",   ones,   200);

    // Negative saturation: every pulse is 0.
    do_reset();
    for (int i = 0; i < 200; i++) upd(-32);
    idle(2);
    check("sat_neg_pulses", pulses, 200);
    check("sat_neg_ones",   ones,   0);
    check("lfsr_200_adv",   dut.r_lfsr, lfsr_after(200));

    // a = 0: ones fraction ~ 1/2.
    do_reset();
    for (int i = 0; i < 4096; i++) upd(0);
    idle(2);
    check("zero_pulses", pulses, 4096);
    check("zero_ones_in_range", (ones >= 1920 && ones <= 2176), 1);

    // a = 32: ones fraction ~ 160/256.
    do_reset();
    for (int i = 0; i < 4096; i++) upd(4);
    idle(2);
    check("a32_pulses", pulses, 4096);
    check("a32_ones_in_range", (ones >= 2432 && ones <= 2688), 1);

    // Zero seed is replaced by the default seed.
    upd(3);
    step(0, 1'b0, 1'b1, 0);
    check("seed0_lfsr", dut.r_lfsr, 'hACE1);
    idle(2);

    // Load 0x1234 then three updates; model uses the 0x1234 sequence.
    step(0, 1'b0, 1'b1, 'h1234);
    check("seed1234_lfsr", dut.r_lfsr, 'h1234);
    upd(5);
    upd(-3);
    upd(0);
    idle(2);

    // Seed load in the same cycle as a stage-2 fire: compare uses old rnd.
    upd(1);
    step(-1, 1'b1, 1'b1, 'hBEEF);
    step(2, 1'b0, 1'b1, 'h00FF);
    idle(2);

    // Reset on the edge after an in_valid pulse: the sample is discarded.
    upd(31);
    do_reset();
    pulses = 0;
    idle(4);
    check("rst_discard_pulses", pulses, 0);
    // First edge after release accepts input; pulse two edges later.
    upd(31);
    idle(1);
    check("post_rst_pulse", p_valid, 1);
    idle(1);

    // 50 unclamped updates: LFSR advances exactly 50 times.
    do_reset();
    for (int i = 0; i < 50; i++) upd(-32);
    idle(2);
    check("lfsr_50_unclamped", dut.r_lfsr, lfsr_after(50));

`ifdef PBIT_UPDATE_CLAMP_EN
    // Clamp to 1 against negative saturation; LFSR still advances.
    do_reset();
    clamp     = 1'b1;
    clamp_val = 1'b1;
    for (int i = 0; i < 50; i++) upd(-32);
    idle(2);
    check("clamp_pulses", pulses, 50);
    check("clamp_ones",   ones,   50);
    check("lfsr_50_clamped", dut.r_lfsr, lfsr_after(50));
    clamp = 1'b0;
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int  mac;
      bit  iv;
      bit  sl;
      int  sd;
      mac = int'($urandom_range(63)) - 32;
      iv  = ($urandom_range(3) != 0);
      sl  = ($urandom_range(31) == 0);
      sd  = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(65535));
`ifdef PBIT_UPDATE_CLAMP_EN
      clamp     = ($urandom_range(7) == 0);
      clamp_val = $urandom_range(1) != 0;
`endif
      step(mac, iv, sl, sd);
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pbit_update.md
PBIT_UPDATE -- requirements
Module: pbit_update

Interface
REQ-001 Parameter SEED, default 16'hACE1, is the LFSR reset value and the substitute for an all-zero seed.
REQ-002 Parameter SLOPE_SHIFT, default 3, is the left-shift applied to the MAC input in the linear activation region.
REQ-003 Port clk, input, 1, is the single rising-edge clock.
REQ-004 Port rst_n, input, 1, is the asynchronous active-low reset.
REQ-005 Port mac_in, input, 6, is the signed Q3.2 weighted sum I_i from the upstream mac (range -8.00..7.75).
REQ-006 Port in_valid, input, 1: mac_in is valid this cycle and an update is requested.
REQ-007 Port seed_load, input, 1: load the seed port into the LFSR on this clock edge.
REQ-008 Port seed, input, 16, is the LFSR load value.
REQ-009 Port p_out, output, 1, is the registered p-bit state: 1 means +1 and 0 means -1.
REQ-010 Port p_valid, output, 1, pulses high for one cycle when p_out has just been updated.

Function
REQ-011 Stage 1 registers mac_in as raw r6 and registers in_valid as v1.
- Stage 1 is free-running.
- There is no backpressure, so a new in_valid is accepted every cycle.
REQ-012 Stage 1 computes the 9-bit signed activation a from raw r6:
- if r6 >= 16, a = +128;
- if r6 <= -16, a = -128;
- otherwise a = r6 << SLOPE_SHIFT, sign-extended to 9 bits (range -120..+120 at default).
- a is registered alongside v1.
REQ-013 The LFSR is 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1:
- shift left by one;
- bit0 takes l[15]^l[13]^l[12]^l[10].
REQ-014 The random sample rnd is l[7:0] interpreted as 8-bit signed (-128..127), then sign-extended to 9 bits.
REQ-015 Stage 2 fires when v1 = 1:
- p_out is set to (a > rnd) as a signed 9-bit comparison;
- p_valid is set to 1;
- the LFSR advances once.
REQ-016 When v1 = 0:
- p_out holds its value;
- p_valid is 0;
- the LFSR holds.
REQ-017 Latency from in_valid sampled high to p_valid high is exactly 2 clock edges; back-to-back inputs produce back-to-back p_valid pulses.
REQ-018 The guaranteed outcomes are:
- a = +128 always gives p_out = 1;
- a = -128 always gives p_out = 0;
- a = 0 gives p_out = 1 exactly when rnd < 0.
REQ-019 seed_load takes priority over advance in the same cycle:
- the LFSR takes seed;
- if seed == 0 it takes SEED instead;
- the in-flight pipeline is not flushed;
- a simultaneous stage-2 compare uses the pre-load rnd.
REQ-020 The LFSR never holds all zeros in any state.

Reset
REQ-021 While rst_n is low, asynchronously: p_out = 0, p_valid = 0, v1 = 0, r6 = 0, a = 0, LFSR = SEED.
REQ-022 Reset asserted mid-operation discards any in-flight sample; no p_valid is produced for that sample after rst_n deasserts.
REQ-023 On the first rising edge after rst_n rises, normal operation resumes; an in_valid on that edge produces p_valid two edges later.

Configuration
REQ-024 Macro PBIT_UPDATE_CLAMP_EN, when defined, adds two inputs:
- clamp, 1 bit;
- clamp_val, 1 bit.
REQ-025 With PBIT_UPDATE_CLAMP_EN defined and clamp = 1 at a stage-2 fire:
- p_out is set to clamp_val;
- p_valid still pulses;
- the LFSR still advances, so the random sequence is independent of clamping.
REQ-026 Without PBIT_UPDATE_CLAMP_EN, the ports clamp and clamp_val do not exist and behaviour is exactly REQ-011..REQ-023.

Verification
REQ-027 The bench shall cover these directed scenarios:
- Reset, then idle 10 cycles -> p_out = 0, p_valid = 0, LFSR = 16'hACE1 throughout.
- mac_in = 6'sd31 (7.75) with in_valid = 1 for 200 cycles -> p_valid high from the 2nd edge on, and p_out = 1 on every pulse.
- mac_in = -6'sd32 (-8.0) with in_valid = 1 for 200 cycles -> p_out = 0 on every pulse.
- mac_in = 0 for 4096 updates -> ones count within 2048±128.
- mac_in = 6'sd4 (a = 32) for 4096 updates -> ones count within 2560±128.
- seed_load with seed = 0 -> LFSR = 16'hACE1.
- seed_load with seed = 16'h1234, then 3 updates -> p_out matches a golden model using rnd from the 16'h1234 sequence.
- in_valid pulse, then rst_n low for 1 cycle on the next edge -> no p_valid after release.
- With PBIT_UPDATE_CLAMP_EN, clamp = 1, clamp_val = 1, mac_in = -6'sd32 for 50 updates -> p_out = 1 on every pulse.
- With PBIT_UPDATE_CLAMP_EN, the LFSR state after 50 updates equals the unclamped run.
